// File: rtl/sc_matrix_mult_acc.sv
// ---------------------------------------------------------------------------
// sc_matrix_mult_acc
//
// Stochastic matrix multiply C = A x B over a bitstream of STREAM_LEN beats.
// Each beat multiplies every (row of A, row of B-transpose) pair bitwise
// (AND for unipolar, XNOR for bipolar). An LFSR-driven N:1 mux then picks one
// product bit per pair, which gives a scaled sum. The selected bits are
// registered onto outputStreams and accumulated by per-element ones-counters.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          begin a run (only honoured in IDLE)
//   bipolar        0 = AND, 1 = XNOR; latched when start is accepted
//   in_valid       input/weight beat valid
//   inputStreams   row i of A at [i*N +: N]
//   weightStreams  row j of B-transpose at [j*N +: N]
//   in_ready       high in RUN
//   outputStreams  registered stream bits, C(i,j) at bit i*O+j
//   out_valid      outputStreams holds the bit of a consumed beat
//   busy           state != IDLE
//   done           one-cycle pulse while in DONE, counts are final
//   counts         ones count of C(i,j) at [(i*O+j)*CNT_W +: CNT_W]
//   counts_valid   counts hold a completed run
//   dbg_state      current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a beat is consumed on a rising edge where in_valid && in_ready.
// The producer holds its data until then; in_ready does not depend on
// in_valid. out_valid is a one-cycle qualifier with no back-pressure.
// ---------------------------------------------------------------------------
module sc_matrix_mult_acc #(
    parameter int          BATCH_SIZE      = 2,
    parameter int          INPUT_FEATURES  = 4,
    parameter int          OUTPUT_FEATURES = 2,
    parameter int          STREAM_LEN      = 256,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int         SEL_W           = $clog2(INPUT_FEATURES),
    localparam int         CNT_W           = $clog2(STREAM_LEN + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic                                            bipolar,
    input  logic                                            in_valid,
    input  logic [BATCH_SIZE*INPUT_FEATURES-1:0]            inputStreams,
    input  logic [OUTPUT_FEATURES*INPUT_FEATURES-1:0]       weightStreams,
    output logic                                            in_ready,
    output logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]           outputStreams,
    output logic                                            out_valid,
    output logic                                            busy,
    output logic                                            done,
    output logic [BATCH_SIZE*OUTPUT_FEATURES*CNT_W-1:0]     counts,
    output logic                                            counts_valid,
    output logic [1:0]                                      dbg_state
);

    localparam int M = BATCH_SIZE;
    localparam int N = INPUT_FEATURES;
    localparam int O = OUTPUT_FEATURES;
    localparam int P = M * O;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STREAM_LEN);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic               mode_q, mode_d;
    logic [P-1:0]       out_bits_q, out_bits_d;
    logic               out_valid_q, out_valid_d;
    logic [P*CNT_W-1:0] counts_q, counts_d;
    logic               counts_valid_q, counts_valid_d;

    logic               accept;
    logic [SEL_W-1:0]   sel;
    logic [P-1:0]       prod;
    logic [15:0]        lfsr_next;
    logic               a_bit;
    logic               w_bit;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign sel       = lfsr_q[SEL_W-1:0];
    assign accept    = in_valid && (state_q == ST_RUN);

    // Only the mux-selected product bit of each pair is needed, so the
    // multiply is done on the selected column rather than all N columns.
    always_comb begin
        prod  = '0;
        a_bit = 1'b0;
        w_bit = 1'b0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < O; j++) begin
                a_bit = inputStreams[i*N + int'(sel)];
                w_bit = weightStreams[j*N + int'(sel)];
                prod[i*O + j] = mode_q ? ~(a_bit ^ w_bit) : (a_bit & w_bit);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        beat_d         = beat_q;
        mode_d         = mode_q;
        out_bits_d     = out_bits_q;
        out_valid_d    = out_valid_q;
        counts_d       = counts_q;
        counts_valid_d = counts_valid_q;

        // Counters trail the stream register by one cycle; this is why the
        // DRAIN state exists (it absorbs the final registered bit).
        if (out_valid_q) begin
            for (int p = 0; p < P; p++) begin
                if (out_bits_q[p] && (counts_q[p*CNT_W +: CNT_W] != CNT_MAX)) begin
                    counts_d[p*CNT_W +: CNT_W] = counts_q[p*CNT_W +: CNT_W] + CNT_ONE;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (start) begin
                    state_d        = ST_RUN;
                    counts_d       = '0;
                    counts_valid_d = 1'b0;
                    beat_d         = '0;
                    lfsr_d         = LFSR_SEED;
                    mode_d         = bipolar;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    out_bits_d  = prod;
                    out_valid_d = 1'b1;
                    lfsr_d      = lfsr_next;
                    beat_d      = beat_q + CNT_ONE;
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                out_valid_d = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                counts_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            lfsr_q         <= LFSR_SEED;
            beat_q         <= '0;
            mode_q         <= 1'b0;
            out_bits_q     <= '0;
            out_valid_q    <= 1'b0;
            counts_q       <= '0;
            counts_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            beat_q         <= beat_d;
            mode_q         <= mode_d;
            out_bits_q     <= out_bits_d;
            out_valid_q    <= out_valid_d;
            counts_q       <= counts_d;
            counts_valid_q <= counts_valid_d;
        end
    end

    assign in_ready      = (state_q == ST_RUN);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign outputStreams = out_bits_q;
    assign out_valid     = out_valid_q;
    assign counts        = counts_q;
    assign counts_valid  = counts_valid_q;
    assign dbg_state     = state_q;

endmodule
